adc_fco_align: RTL and testbench

Frame-clock alignment controller for the LTC2195-style ADC serial input path on the BPM board. It sweeps the FCO lane IDELAY tap and finds the widest stable data-eye window. It then parks the tap at the window centre and issues ISERDES bitslips until the deserialised FCO word matches the expected frame pattern. It also gives the PS a manual tap load path for the existing ADC delay value and strobe registers. It sits between the PS register block and the ADC IDELAY/ISERDES primitives in the adc_clk domain.

---
 rtl/adc_fco_align.sv | 241 ++++++++++++++++++++++++
 tb/tb_adc_fco_align.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_fco_align.sv
// FCO lane alignment: sweeps IDELAY taps for the widest stable eye, centres on it,
// then bitslips the ISERDES until the frame word matches EXP_PATTERN.
module adc_fco_align #(
    parameter logic [7:0]  EXP_PATTERN = 8'hF0,
    parameter int unsigned TAP_MAX     = 31,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned CHECK_CYC   = 16,
    parameter int unsigned MAX_SLIPS   = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] fco_word,
    input  logic [8:0] sw_dly_val,
    input  logic       sw_dly_str,
    output logic [8:0] dly_tap,
    output logic       dly_load,
    output logic       bitslip,
    output logic       busy,
    output logic       locked,
    output logic       fail,
    output logic [8:0] win_start,
    output logic [9:0] win_len,
    output logic [3:0] slip_cnt
);

    localparam logic [8:0]  TapMaxC    = 9'(TAP_MAX);
    localparam logic [15:0] SettleLast = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] CheckLast  = 16'(CHECK_CYC - 1);
    localparam logic [3:0]  MaxSlipsC  = 4'(MAX_SLIPS);

    typedef enum logic [3:0] {
        StIdle, StLoad, StSettle, StCheck, StEval, StCenter,
        StSlip, StSlipSettle, StSlipCheck, StLocked, StFail
    } state_e;

    state_e      state_q;
    logic [8:0]  tap_q;
    logic [15:0] cyc_q;
    logic [7:0]  first_q;
    logic        stable_q;
    logic        match_q;
    logic [8:0]  cur_start_q;
    logic [9:0]  cur_len_q;
    logic [8:0]  best_start_q;
    logic [9:0]  best_len_q;
    logic        str_q;
    logic        str_arm_q;

    logic        can_accept;
    logic        str_rise;
    logic [8:0]  sw_tap;
    logic        tap_last;
    logic        settle_last;
    logic        check_last;
    logic        stable_now;
    logic        match_now;
    logic [8:0]  ext_start;
    logic [9:0]  ext_len;
    logic [8:0]  close_start;
    logic [9:0]  close_len;
    logic        run_closes;
    logic [8:0]  center_tap;

    always_comb begin
        can_accept  = (state_q == StIdle) || (state_q == StLocked) || (state_q == StFail);
        // Arm bit keeps a strobe held high through reset from looking like an edge.
        str_rise    = sw_dly_str && !str_q && str_arm_q;
        sw_tap      = (sw_dly_val > TapMaxC) ? TapMaxC : sw_dly_val;
        tap_last    = (tap_q == TapMaxC);
        settle_last = (cyc_q == SettleLast);
        check_last  = (cyc_q == CheckLast);
        stable_now  = (cyc_q == '0) ? 1'b1 : (stable_q && (fco_word == first_q));
        match_now   = ((cyc_q == '0) || match_q) && (fco_word == EXP_PATTERN);
        ext_start   = (cur_len_q == '0) ? tap_q : cur_start_q;
        ext_len     = cur_len_q + 10'd1;
        close_start = stable_q ? ext_start : cur_start_q;
        close_len   = stable_q ? ext_len : cur_len_q;
        run_closes  = !stable_q || tap_last;
        center_tap  = best_start_q + best_len_q[9:1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            tap_q        <= '0;
            cyc_q        <= '0;
            first_q      <= '0;
            stable_q     <= 1'b0;
            match_q      <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            str_q        <= 1'b0;
            str_arm_q    <= 1'b0;
            dly_tap      <= '0;
            dly_load     <= 1'b0;
            bitslip      <= 1'b0;
            busy         <= 1'b0;
            locked       <= 1'b0;
            fail         <= 1'b0;
            win_start    <= '0;
            win_len      <= '0;
            slip_cnt     <= '0;
        end else begin
            dly_load  <= 1'b0;
            bitslip   <= 1'b0;
            str_q     <= sw_dly_str;
            str_arm_q <= 1'b1;

            case (state_q)
                StIdle, StLocked, StFail: begin
                    if (start) begin
                        locked       <= 1'b0;
                        fail         <= 1'b0;
                        win_start    <= '0;
                        win_len      <= '0;
                        slip_cnt     <= '0;
                        tap_q        <= '0;
                        cur_start_q  <= '0;
                        cur_len_q    <= '0;
                        best_start_q <= '0;
                        best_len_q   <= '0;
                        busy         <= 1'b1;
                        state_q      <= StLoad;
                    end else if (can_accept && str_rise) begin
                        dly_tap  <= sw_tap;
                        dly_load <= 1'b1;
                        locked   <= 1'b0;
                        fail     <= 1'b0;
                        state_q  <= StIdle;
                    end
                end

                StLoad: begin
                    dly_tap  <= tap_q;
                    dly_load <= 1'b1;
                    cyc_q    <= '0;
                    state_q  <= StSettle;
                end

                StSettle: begin
                    if (settle_last) begin
                        cyc_q   <= '0;
                        state_q <= StCheck;
                    end else begin
                        cyc_q <= cyc_q + 16'd1;
                    end
                end

                StCheck: begin
                    if (cyc_q == '0) begin
                        first_q <= fco_word;
                    end
                    stable_q <= stable_now;
                    if (check_last) begin
                        cyc_q   <= '0;
                        state_q <= StEval;
                    end else begin
                        cyc_q <= cyc_q + 16'd1;
                    end
                end

                StEval: begin
                    // Strictly-longer replacement keeps the lowest-starting run on ties.
                    if (run_closes && (close_len > best_len_q)) begin
                        best_start_q <= close_start;
                        best_len_q   <= close_len;
                    end
                    if (stable_q && !tap_last) begin
                        cur_start_q <= ext_start;
                        cur_len_q   <= ext_len;
                    end else begin
                        cur_len_q <= '0;
                    end
                    if (tap_last) begin
                        state_q <= StCenter;
                    end else begin
                        tap_q   <= tap_q + 9'd1;
                        state_q <= StLoad;
                    end
                end

                StCenter: begin
                    if (best_len_q == '0) begin
                        fail    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StFail;
                    end else begin
                        win_start <= best_start_q;
                        win_len   <= best_len_q;
                        dly_tap   <= center_tap;
                        dly_load  <= 1'b1;
                        cyc_q     <= '0;
                        state_q   <= StSlipSettle;
                    end
                end

                StSlip: begin
                    bitslip  <= 1'b1;
                    slip_cnt <= slip_cnt + 4'd1;
                    cyc_q    <= '0;
                    state_q  <= StSlipSettle;
                end

                StSlipSettle: begin
                    if (settle_last) begin
                        cyc_q   <= '0;
                        state_q <= StSlipCheck;
                    end else begin
                        cyc_q <= cyc_q + 16'd1;
                    end
                end

                StSlipCheck: begin
                    match_q <= match_now;
                    if (check_last) begin
                        cyc_q <= '0;
                        if (match_now) begin
                            locked  <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StLocked;
                        end else if (slip_cnt == MaxSlipsC) begin
                            fail    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StFail;
                        end else begin
                            state_q <= StSlip;
                        end
                    end else begin
                        cyc_q <= cyc_q + 16'd1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_fco_align.sv
// Bench for adc_fco_align: IDELAY/ISERDES model driving fco_word, with a queue of
// expected calibration outcomes compared whenever busy drops.
module tb_adc_fco_align;

    logic       tb_ACLK = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] fco_word = 8'h00;
    logic [8:0] sw_dly_val;
    logic       sw_dly_str;
    logic [8:0] dly_tap;
    logic       dly_load;
    logic       bitslip;
    logic       busy;
    logic       locked;
    logic       fail;
    logic [8:0] win_start;
    logic [9:0] win_len;
    logic [3:0] slip_cnt;

    typedef struct packed {
        logic       lk;
        logic       fl;
        logic [8:0] ws;
        logic [9:0] wl;
        logic [8:0] tap;
        logic [3:0] sc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_loads = 0;
    int n_slips = 0;
    int n_overlap = 0;
    int n_long = 0;
    int busy_cyc = 0;

    int lo0 = 1000, hi0 = -1, lo1 = 1000, hi1 = -1;
    logic [7:0] base = 8'h87;
    int   m_tap = 0;
    int   m_rot = 0;
    logic phase = 1'b0;
    logic prev_load = 1'b0;
    logic prev_slip = 1'b0;

    adc_fco_align dut (
        .clk        (tb_ACLK),
        .rstn       (rstn),
        .start      (start),
        .fco_word   (fco_word),
        .sw_dly_val (sw_dly_val),
        .sw_dly_str (sw_dly_str),
        .dly_tap    (dly_tap),
        .dly_load   (dly_load),
        .bitslip    (bitslip),
        .busy       (busy),
        .locked     (locked),
        .fail       (fail),
        .win_start  (win_start),
        .win_len    (win_len),
        .slip_cnt   (slip_cnt)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic bit in_eye(input int t);
        return ((t >= lo0) && (t <= hi0)) || ((t >= lo1) && (t <= hi1));
    endfunction

    // Delay line / deserialiser model; a tap load also resets the slip phase.
    always @(posedge tb_ACLK) begin
        #1;
        if (dly_load) begin
            m_tap = int'(dly_tap);
            m_rot = 0;
            n_loads++;
        end
        if (bitslip) begin
            m_rot = (m_rot + 1) % 8;
            n_slips++;
        end
        if (dly_load && bitslip) n_overlap++;
        if ((dly_load && prev_load) || (bitslip && prev_slip)) n_long++;
        prev_load = dly_load;
        prev_slip = bitslip;
        if (busy) busy_cyc++;
        phase = ~phase;
        fco_word = in_eye(m_tap) ? rotl(base, m_rot) : (phase ? 8'h55 : 8'hAA);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tap"}, 32'(dly_tap), 0);
        check({tag, "_load"}, 32'(dly_load), 0);
        check({tag, "_slip"}, 32'(bitslip), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_fail"}, 32'(fail), 0);
        check({tag, "_ws"}, 32'(win_start), 0);
        check({tag, "_wl"}, 32'(win_len), 0);
        check({tag, "_sc"}, 32'(slip_cnt), 0);
    endtask

    task automatic run_cal(input string tag, input int a0, input int b0, input int a1,
                           input int b1, input logic [7:0] w, input exp_t e,
                           input int exp_slips, input bit with_str, output int bcyc);
        exp_t got_e;
        int   cnt;
        lo0 = a0; hi0 = b0; lo1 = a1; hi1 = b1; base = w;
        exp_q.push_back(e);
        @(negedge tb_ACLK);
        n_slips  = 0;
        busy_cyc = 0;
        start    = 1'b1;
        if (with_str) begin
            sw_dly_val = 9'd3;
            sw_dly_str = 1'b1;
        end
        @(posedge tb_ACLK);
        #2;
        start = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 1);
        check({tag, "_flags_clr"}, 32'({locked, fail}), 0);
        check({tag, "_no_early_load"}, 32'(dly_load), 0);
        @(posedge tb_ACLK);
        #2;
        check({tag, "_first_load"}, 32'({dly_load, dly_tap}), 32'({1'b1, 9'd0}));
        cnt = 0;
        while (busy && cnt < 3000) begin
            @(posedge tb_ACLK);
            #2;
            cnt++;
        end
        check({tag, "_done"}, 32'(busy), 0);
        check({tag, "_q_nonempty"}, 32'(exp_q.size() != 0), 1);
        got_e = exp_q.pop_front();
        check({tag, "_locked"}, 32'(locked), 32'(got_e.lk));
        check({tag, "_fail"}, 32'(fail), 32'(got_e.fl));
        check({tag, "_ws"}, 32'(win_start), 32'(got_e.ws));
        check({tag, "_wl"}, 32'(win_len), 32'(got_e.wl));
        check({tag, "_tap"}, 32'(dly_tap), 32'(got_e.tap));
        check({tag, "_sc"}, 32'(slip_cnt), 32'(got_e.sc));
        check({tag, "_slip_pulses"}, 32'(n_slips), 32'(exp_slips));
        bcyc = busy_cyc;
        if (with_str) begin
            @(negedge tb_ACLK);
            sw_dly_str = 1'b0;
        end
    endtask

    initial begin
        int bc;
        int cnt;
        rstn       = 1'b0;
        start      = 1'b0;
        sw_dly_val = '0;
        sw_dly_str = 1'b0;
        repeat (3) @(posedge tb_ACLK);
        #2;
        check_reset_vals("reset");
        @(negedge tb_ACLK);
        rstn = 1'b1;
        repeat (3) @(posedge tb_ACLK);

        // Manual load with an out-of-range value clamps to TAP_MAX.
        @(negedge tb_ACLK);
        n_loads    = 0;
        sw_dly_val = 9'h1FF;
        sw_dly_str = 1'b1;
        @(posedge tb_ACLK);
        #2;
        check("man_load_pulse", 32'({dly_load, dly_tap}), 32'({1'b1, 9'd31}));
        repeat (4) @(posedge tb_ACLK);
        #2;
        check("man_load_count", 32'(n_loads), 1);
        check("man_still_idle", 32'(busy), 0);
        @(negedge tb_ACLK);
        sw_dly_str = 1'b0;

        run_cal("nominal", 10, 20, 1000, -1, 8'h87,
                '{1'b1, 1'b0, 9'd10, 10'd11, 9'd15, 4'd5}, 5, 1'b0, bc);
        run_cal("restart", 10, 20, 1000, -1, 8'h87,
                '{1'b1, 1'b0, 9'd10, 10'd11, 9'd15, 4'd5}, 5, 1'b0, bc);
        run_cal("no_eye", 1000, -1, 1000, -1, 8'h87,
                '{1'b0, 1'b1, 9'd0, 10'd0, 9'd31, 4'd0}, 0, 1'b0, bc);
        check("no_eye_busy_time", 32'((bc >= 833) && (bc <= 835)), 1);
        run_cal("no_pattern", 4, 9, 1000, -1, 8'hAA,
                '{1'b0, 1'b1, 9'd4, 10'd6, 9'd7, 4'd8}, 8, 1'b0, bc);
        run_cal("win_longer", 3, 6, 12, 20, 8'h87,
                '{1'b1, 1'b0, 9'd12, 10'd9, 9'd16, 4'd5}, 5, 1'b0, bc);
        run_cal("win_tie", 3, 7, 20, 24, 8'h87,
                '{1'b1, 1'b0, 9'd3, 10'd5, 9'd5, 4'd5}, 5, 1'b0, bc);
        run_cal("win_open_end", 25, 31, 1000, -1, 8'h87,
                '{1'b1, 1'b0, 9'd25, 10'd7, 9'd28, 4'd5}, 5, 1'b0, bc);

        // Strobe edge arriving mid-sweep must be dropped.
        fork
            run_cal("str_busy", 10, 20, 1000, -1, 8'h87,
                    '{1'b1, 1'b0, 9'd10, 10'd11, 9'd15, 4'd5}, 5, 1'b0, bc);
            begin
                repeat (100) @(negedge tb_ACLK);
                sw_dly_val = 9'd3;
                sw_dly_str = 1'b1;
                @(posedge tb_ACLK);
                #2;
                check("str_busy_kept", 32'(busy), 1);
            end
        join
        @(negedge tb_ACLK);
        sw_dly_str = 1'b0;

        run_cal("str_with_start", 10, 20, 1000, -1, 8'h87,
                '{1'b1, 1'b0, 9'd10, 10'd11, 9'd15, 4'd5}, 5, 1'b1, bc);

        // Reset in the middle of the sweep, with the strobe held high across it.
        lo0 = 10; hi0 = 20; lo1 = 1000; hi1 = -1;
        @(negedge tb_ACLK);
        start = 1'b1;
        @(negedge tb_ACLK);
        start = 1'b0;
        cnt = 0;
        while (!(dly_load && dly_tap == 9'd12) && cnt < 1000) begin
            @(posedge tb_ACLK);
            #2;
            cnt++;
        end
        check("mid_reach_tap12", 32'(dly_tap), 12);
        repeat (3) @(negedge tb_ACLK);
        rstn       = 1'b0;
        sw_dly_val = 9'd5;
        sw_dly_str = 1'b1;
        #2;
        n_loads = 0;
        check_reset_vals("mid_reset");
        repeat (2) @(negedge tb_ACLK);
        rstn = 1'b1;
        repeat (6) @(posedge tb_ACLK);
        #2;
        check("mid_no_load", 32'(n_loads), 0);
        check("mid_idle", 32'({busy, dly_tap}), 0);
        @(negedge tb_ACLK);
        sw_dly_str = 1'b0;

        check("pulse_overlap", 32'(n_overlap), 0);
        check("pulse_width", 32'(n_long), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
